// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Defining IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its CSUM state.
package imem_loader_pkg;

   // Defaults tied to the instruction ROM: one word per row, word index = pc[4:1].
   localparam int IMEM_ADDR_W = 4;
   localparam int IMEM_DEPTH  = 15;
   localparam int IMEM_WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM = 3'd4,
`endif
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader for the writable instruction RAM: length byte, N high/low word pairs,
// optional XOR checksum (IMEM_LOADER_CHECKSUM_EN); holds the core while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int WORD_W = IMEM_WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              cpu_pc_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] word_count
);

   state_t            state;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        hi_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif
   logic              xfer;
   logic              last_word;

   assign xfer      = byte_valid && byte_ready;
   // word_count still lags by the in-flight write, so this compares the word being taken now.
   assign last_word = (word_count + ADDR_W'(1)) == len;
   assign imem_addr = addr;

   // NOTE: state uses non-blocking assignments only, so every branch below reads pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         len        <= '0;
         addr       <= '0;
         hi_byte    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b0;
         cpu_pc_rst <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
      end else begin
         imem_we    <= 1'b0;
         cpu_pc_rst <= 1'b0;
         // The write retires here, overlapping whichever byte the FSM takes this cycle.
         if (imem_we) begin
            addr       <= addr + ADDR_W'(1);
            word_count <= word_count + ADDR_W'(1);
         end

         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state      <= ST_LEN;
                  byte_ready <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  word_count <= '0;
                  addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= '0;
`endif
               end
            end
            ST_LEN: begin
               if (xfer) begin
                  if (byte_in == 8'd0 || byte_in > 8'(DEPTH)) begin
                     state      <= ST_ERR;
                     byte_ready <= 1'b0;
                     err        <= 1'b1;
                  end else begin
                     len   <= byte_in[ADDR_W-1:0];
                     state <= ST_HI;
                  end
               end
            end
            ST_HI: begin
               if (xfer) begin
                  hi_byte <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum    <= csum ^ byte_in;
`endif
                  state   <= ST_LO;
               end
            end
            ST_LO: begin
               if (xfer) begin
                  imem_we    <= 1'b1;
                  imem_wdata <= {hi_byte, byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= csum ^ byte_in;
`endif
                  if (!last_word) begin
                     state <= ST_HI;
                  end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state <= ST_CSUM;
`else
                     // Close the port and park here until the final write retires.
                     byte_ready <= 1'b0;
`endif
                  end
               end
`ifndef IMEM_LOADER_CHECKSUM_EN
               else if (!byte_ready && imem_we) begin
                  state      <= ST_DONE;
                  cpu_hold   <= 1'b0;
                  cpu_pc_rst <= 1'b1;
                  done       <= 1'b1;
               end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  byte_ready <= 1'b0;
                  if (byte_in == csum) begin
                     state      <= ST_DONE;
                     cpu_hold   <= 1'b0;
                     cpu_pc_rst <= 1'b1;
                     done       <= 1'b1;
                  end else begin
                     // cpu_hold stays high so the core never runs a corrupt image.
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state      <= ST_IDLE;
               byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as bytes are driven and
// popped by a write monitor; works with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = IMEM_ADDR_W;
   localparam int WORD_W = IMEM_WORD_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   logic              clk        = 1'b0;
   logic              rst_n      = 1'b0;
   logic              start      = 1'b0;
   logic [7:0]        byte_in    = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;
   logic              cpu_hold;
   logic              cpu_pc_rst;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] word_count;

   int          n_tests    = 0;
   int          n_fail     = 0;
   int          pc_rst_cnt = 0;
   wr_t         sb[$];
   logic [15:0] img[$];

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .cpu_pc_rst (cpu_pc_rst),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold,
                  cpu_pc_rst, done, err, word_count});
   endfunction

   // Write monitor: every imem_we cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (cpu_pc_rst) pc_rst_cnt++;
      if (imem_we) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(imem_we), 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(imem_addr), 32'(e.addr));
            check("wr_data", 32'(imem_wdata), 32'(e.data));
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input logic [7:0] b, input bit toggle);
      int n = 0;
      if (toggle) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
      else @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic load_image(input bit bad, input bit toggle, input int poke_at);
      logic [7:0] cs  = 8'h00;
      int         lat = 1;
      pulse_start();
      send_byte(8'(img.size()), toggle);
      for (int i = 0; i < img.size(); i++) begin
         sb.push_back('{addr: ADDR_W'(i), data: img[i]});
         if (i == poke_at) pulse_start();
         send_byte(img[i][15:8], toggle);
         send_byte(img[i][7:0], toggle);
         cs = cs ^ img[i][15:8] ^ img[i][7:0];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs ^ 8'(bad), toggle);
`endif
      if (!bad) begin
         while (!cpu_pc_rst && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("pc_rst_latency", 32'(lat), 32'(EXP_LAT));
         check("done_with_pc_rst", 32'(done), 32'd1);
         @(negedge clk);
         check("pc_rst_one_cycle", 32'(cpu_pc_rst), 32'd0);
      end
   endtask

   initial begin
      #1 check("reset_outputs", all_outputs(), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_outputs", all_outputs(), 32'd0);

      // Directed two-word image.
      img = '{16'h2048, 16'h000A};
      load_image(1'b0, 1'b0, -1);
      check("good_done", 32'(done), 32'd1);
      check("good_err", 32'(err), 32'd0);
      check("good_word_count", 32'(word_count), 32'd2);
      check("good_hold_released", 32'(cpu_hold), 32'd0);
      check("good_pc_rst_count", 32'(pc_rst_cnt), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Same image with a corrupted checksum byte.
      load_image(1'b1, 1'b0, -1);
      repeat (2) @(negedge clk);
      check("bad_err", 32'(err), 32'd1);
      check("bad_hold", 32'(cpu_hold), 32'd1);
      check("bad_done", 32'(done), 32'd0);
      check("bad_ready", 32'(byte_ready), 32'd0);
      check("bad_no_pc_rst", 32'(pc_rst_cnt), 32'd1);
      pulse_start();
      check("start_clears_err", 32'(err), 32'd0);
`else
      pulse_start();
`endif

      // Invalid lengths: zero and DEPTH+1.
      send_byte(8'h00, 1'b0);
      check("len0_err", 32'(err), 32'd1);
      check("len0_ready", 32'(byte_ready), 32'd0);
      check("len0_hold", 32'(cpu_hold), 32'd1);
      pulse_start();
      check("restart_clears_err", 32'(err), 32'd0);
      send_byte(8'h10, 1'b0);
      check("len16_err", 32'(err), 32'd1);
      check("len16_ready", 32'(byte_ready), 32'd0);

      // Full-depth image with byte_valid toggling every cycle.
      img.delete();
      for (int i = 0; i < 15; i++) img.push_back(16'($urandom));
      load_image(1'b0, 1'b1, -1);
      check("full_word_count", 32'(word_count), 32'd15);
      check("full_done", 32'(done), 32'd1);
      check("full_err", 32'(err), 32'd0);

      // Asynchronous reset while word 3 sits in LO.
      img = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      pulse_start();
      send_byte(8'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{addr: ADDR_W'(i), data: img[i]});
         send_byte(img[i][15:8], 1'b0);
         send_byte(img[i][7:0], 1'b0);
      end
      send_byte(img[2][15:8], 1'b0);
      check("pre_reset_hold", 32'(cpu_hold), 32'd1);
      check("pre_reset_count", 32'(word_count), 32'd2);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", all_outputs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_idle", all_outputs(), 32'd0);
      check("partial_writes_seen", 32'(sb.size()), 32'd0);
      img = '{16'hBEEF};
      load_image(1'b0, 1'b0, -1);
      check("restart_word_count", 32'(word_count), 32'd1);

      // start pulsed while the FSM waits in HI must be ignored.
      img = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
      load_image(1'b0, 1'b0, 1);
      check("poke_done", 32'(done), 32'd1);
      check("poke_err", 32'(err), 32'd0);
      check("poke_word_count", 32'(word_count), 32'd3);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
